// File: rtl/signal_measure_pkg.sv
// Shared definitions for the signal_measure analyser.
// Contents:
//   meas_state_e - crossing-detector states (seek low, arm, run high, run low)
//   Def*         - default sample width, counter width, hysteresis and mid-level
package signal_measure_pkg;

  parameter int unsigned DefDataW   = 12;
  parameter int unsigned DefCntW    = 16;
  parameter int unsigned DefHyst    = 64;
  parameter int unsigned DefMidInit = 2048;

  typedef enum logic [1:0] {
    StSeek,
    StArm,
    StRunHi,
    StRunLo
  } meas_state_e;

endpackage

// File: rtl/signal_measure_if.sv
// Sample/measurement bundle between a sample source and signal_measure.
// Signals:
//   wave_in    - unsigned sample            (source -> analyser)
//   in_valid   - sample strobe              (source -> analyser)
//   period     - accepted samples per period
//   amp_max    - largest sample of the last period
//   amp_min    - smallest sample of the last period
//   amp_pp     - amp_max - amp_min
//   meas_valid - one-cycle pulse when the results update
//   no_signal  - level, set on timeout, cleared by the next publish
// Modports: master = sample source / result consumer, slave = analyser.
interface signal_measure_if import signal_measure_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW
) ();

  logic [DATA_W-1:0] wave_in;
  logic              in_valid;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] amp_max;
  logic [DATA_W-1:0] amp_min;
  logic [DATA_W-1:0] amp_pp;
  logic              meas_valid;
  logic              no_signal;

  modport master (
    output wave_in, in_valid,
    input  period, amp_max, amp_min, amp_pp, meas_valid, no_signal
  );

  modport slave (
    input  wave_in, in_valid,
    output period, amp_max, amp_min, amp_pp, meas_valid, no_signal
  );

endinterface

// File: rtl/signal_measure_minmax_track.sv
// minmax_track: running minimum/maximum of an accepted sample stream.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   en               - sample accepted this cycle
//   load             - start a new window with this sample (min = max = sample)
//   sample           - sample value
//   cur_min/cur_max  - registered extremes of the current window
//   nxt_min/nxt_max  - extremes including this cycle's sample (combinational)
module minmax_track import signal_measure_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] cur_min,
  output logic [DATA_W-1:0] cur_max,
  output logic [DATA_W-1:0] nxt_min,
  output logic [DATA_W-1:0] nxt_max
);

  logic [DATA_W-1:0] min_q, max_q;

  always_comb begin
    nxt_min = min_q;
    nxt_max = max_q;
    if (load) begin
      nxt_min = sample;
      nxt_max = sample;
    end else begin
      if (sample < min_q) nxt_min = sample;
      if (sample > max_q) nxt_max = sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (en) begin
      min_q <= nxt_min;
      max_q <= nxt_max;
    end
  end

  assign cur_min = min_q;
  assign cur_max = max_q;

endmodule

// File: rtl/signal_measure.sv
// signal_measure: periodic-waveform analyser.
// Detects rising crossings of an adaptive mid-level with hysteresis, counts accepted
// samples between crossings, tracks min/max per period and publishes period, min, max
// and peak-to-peak with a one-cycle meas_valid pulse. A full period count is treated as
// "no signal": the mid-level is re-centred (or reset) and no_signal is raised.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - signal_measure_if slave: wave_in/in_valid in; period, amp_max, amp_min,
//         amp_pp, meas_valid, no_signal out
// Build option: define SIGNAL_MEASURE_AVG_EN to average four consecutive periods and
// publish only on every fourth crossing.
module signal_measure import signal_measure_pkg::*; #(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned HYST     = DefHyst,
  parameter int unsigned MID_INIT = DefMidInit
) (
  input  logic            clk,
  input  logic            rst,
  signal_measure_if.slave bus
);

  localparam logic [DATA_W:0]   MaxVal   = {1'b0, {DATA_W{1'b1}}};
  localparam logic [DATA_W:0]   HystW    = (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0]   TwoHystW = (DATA_W+1)'(2 * HYST);
  localparam logic [DATA_W-1:0] MidInitV = DATA_W'(MID_INIT);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  function automatic logic [DATA_W-1:0] midpoint(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W:1];
  endfunction

  // Input register
  logic [DATA_W-1:0] wave_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wave_q  <= bus.wave_in;
      valid_q <= bus.in_valid;
    end
  end

  meas_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] mid_q, mid_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] amp_max_q, amp_max_d;
  logic [DATA_W-1:0] amp_min_q, amp_min_d;
  logic [DATA_W-1:0] amp_pp_q, amp_pp_d;
  logic              meas_valid_q, meas_valid_d;
  logic              no_signal_q, no_signal_d;

`ifdef SIGNAL_MEASURE_AVG_EN
  logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       avg_cnt_q, avg_cnt_d;
`endif

  // Thresholds, saturated to the sample range
  logic [DATA_W:0]   hi_sum, lo_diff;
  logic [DATA_W-1:0] thr_hi, thr_lo;

  always_comb begin
    hi_sum  = {1'b0, mid_q} + HystW;
    lo_diff = {1'b0, mid_q} - HystW;
    thr_hi  = (hi_sum > MaxVal) ? MaxVal[DATA_W-1:0] : hi_sum[DATA_W-1:0];
    thr_lo  = ({1'b0, mid_q} < HystW) ? '0 : lo_diff[DATA_W-1:0];
  end

  logic accept, is_hi, is_lo, crossing, start, restart, timeout, fresh;

  assign accept   = valid_q;
  assign is_hi    = (wave_q >= thr_hi);
  assign is_lo    = (wave_q <= thr_lo);
  assign crossing = accept && (state_q == StRunLo) && is_hi;
  assign start    = accept && (state_q == StArm) && is_hi;
  assign restart  = crossing || start;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // A crossing on the would-be timeout sample wins over the timeout.
  assign timeout  = accept && !restart && (cnt_inc == CntMax);
  // Counter at zero means the window is empty (after reset or timeout).
  assign fresh    = (cnt_q == '0);

  logic [DATA_W-1:0] cur_min, cur_max, nxt_min, nxt_max, spread;

  minmax_track #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .load    (restart || fresh),
    .sample  (wave_q),
    .cur_min (cur_min),
    .cur_max (cur_max),
    .nxt_min (nxt_min),
    .nxt_max (nxt_max)
  );

  assign spread = nxt_max - nxt_min;

  // Crossing FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      StSeek:  if (accept && is_lo) state_d = StArm;
      StArm:   if (start)           state_d = StRunHi;
      StRunHi: if (accept && is_lo) state_d = StRunLo;
      StRunLo: if (crossing)        state_d = StRunHi;
      default:                      state_d = StSeek;
    endcase
    if (timeout) state_d = StSeek;
  end

  // Window counter; the crossing sample is the first sample of the new window.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (restart)      cnt_d = CNT_W'(1);
      else if (timeout) cnt_d = '0;
      else              cnt_d = cnt_inc;
    end
  end

  // Publish / timeout handling
  always_comb begin
    period_d     = period_q;
    amp_max_d    = amp_max_q;
    amp_min_d    = amp_min_q;
    amp_pp_d     = amp_pp_q;
    meas_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    mid_d        = mid_q;
`ifdef SIGNAL_MEASURE_AVG_EN
    acc_d        = acc_q;
    avg_cnt_d    = avg_cnt_q;
    acc_sum      = acc_q + {2'b00, cnt_q};
`endif
    if (crossing) begin
      mid_d       = midpoint(cur_max, cur_min);
      no_signal_d = 1'b0;
`ifdef SIGNAL_MEASURE_AVG_EN
      if (avg_cnt_q == 2'd3) begin
        period_d     = acc_sum[CNT_W+1:2];
        amp_max_d    = cur_max;
        amp_min_d    = cur_min;
        amp_pp_d     = cur_max - cur_min;
        meas_valid_d = 1'b1;
        acc_d        = '0;
        avg_cnt_d    = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + 2'd1;
      end
`else
      period_d     = cnt_q;
      amp_max_d    = cur_max;
      amp_min_d    = cur_min;
      amp_pp_d     = cur_max - cur_min;
      meas_valid_d = 1'b1;
`endif
    end else if (timeout) begin
      no_signal_d = 1'b1;
      // Re-centre on a real but badly placed signal; fall back on a flat one.
      mid_d = ({1'b0, spread} >= TwoHystW) ? midpoint(nxt_max, nxt_min) : MidInitV;
`ifdef SIGNAL_MEASURE_AVG_EN
      acc_d     = '0;
      avg_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSeek;
      cnt_q        <= '0;
      mid_q        <= MidInitV;
      period_q     <= '0;
      amp_max_q    <= '0;
      amp_min_q    <= '0;
      amp_pp_q     <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b0;
`ifdef SIGNAL_MEASURE_AVG_EN
      acc_q        <= '0;
      avg_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mid_q        <= mid_d;
      period_q     <= period_d;
      amp_max_q    <= amp_max_d;
      amp_min_q    <= amp_min_d;
      amp_pp_q     <= amp_pp_d;
      meas_valid_q <= meas_valid_d;
      no_signal_q  <= no_signal_d;
`ifdef SIGNAL_MEASURE_AVG_EN
      acc_q        <= acc_d;
      avg_cnt_q    <= avg_cnt_d;
`endif
    end
  end

  assign bus.period     = period_q;
  assign bus.amp_max    = amp_max_q;
  assign bus.amp_min    = amp_min_q;
  assign bus.amp_pp     = amp_pp_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.no_signal  = no_signal_q;

endmodule

// File: doc/signal_measure.md
# signal_measure

Sample-stream analyser that sits downstream of the signal generator's 12-bit `wave_out` (or an ADC capture of it) and measures what the generator produces. It detects rising crossings of an adaptive mid-level with hysteresis and counts accepted samples per period. Over each period it tracks the minimum and maximum sample, then publishes period, min, max and peak-to-peak with a one-cycle valid pulse. Results feed the display/self-test logic.

## Interface
- `DATA_W`, 12, sample width
- `CNT_W`, 16, period counter width; a full count is the no-signal timeout
- `HYST`, 64, hysteresis half-width in LSB around the mid-level
- `MID_INIT`, 2048, mid-level after reset and after a flat-signal timeout
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wave_in`  in  DATA_W  unsigned sample
- `in_valid`  in  1  sample strobe; samples with `in_valid`=0 are ignored entirely
- `period`  out  CNT_W  accepted samples per period
- `amp_max`, `amp_min`  out  DATA_W  extremes over the last period
- `amp_pp`  out  DATA_W  `amp_max` − `amp_min`
- `meas_valid`  out  1  one-cycle pulse when the outputs above update
- `no_signal`  out  1  level; set on timeout, cleared on next publish

## Operation
- **Thresholds**
  - `thr_hi` = min(mid+HYST, 2^DATA_W−1); `thr_lo` = max(mid−HYST, 0).
  - `mid` is a DATA_W register.
- **States**
  - SEEK: wait for a sample ≤ `thr_lo`, then go to ARM.
  - ARM: wait for a sample ≥ `thr_hi`. This first crossing only starts a window: counter=1, min=max=sample; go to RUN_HI. Nothing is published.
  - RUN_HI: wait for a sample ≤ `thr_lo`, then go to RUN_LO.
  - RUN_LO: a sample ≥ `thr_hi` is a crossing. On a crossing, publish, restart the window with the crossing sample, and go to RUN_HI.
- **Window bookkeeping**
  - Every accepted sample outside a crossing increments the counter and updates the running min/max.
  - The crossing sample belongs to the new window, not the old one.
- **Publish**
  - Outputs take the window's counter, max, min and max−min.
  - `mid` ← (max+min)>>1, computed with a DATA_W+1-bit sum.
  - `no_signal` ← 0; `meas_valid` pulses.
- **Timeout**
  - In any state, when the counter reaches 2^CNT_W−1:
    - If max−min ≥ 2·HYST: `mid` ← (max+min)>>1.
    - Otherwise: `mid` ← MID_INIT.
  - In both cases: `no_signal` ← 1, no `meas_valid`, the counter, min and max restart from the next sample, and the state goes to SEEK.
  - The counter also runs (and min/max track) in SEEK/ARM, so a badly placed `mid` self-corrects.
- **Simultaneous events**
  - A crossing on the timeout sample counts as a crossing; the timeout is ignored.
- **Reset values**
  - All outputs are 0; `mid`=MID_INIT; state SEEK; counters 0.
  - Reset mid-window discards the window with no pulse.

## Timing
- `wave_in`/`in_valid` are registered once at the input.
- A crossing sample presented in cycle N gives updated outputs and `meas_valid`=1 in cycle N+2. Outputs hold until the next publish.
- `no_signal` rises in cycle N+2 after the timeout sample.
- There is no backpressure; a sample is accepted every cycle `in_valid`=1.
- Minimum reportable period is 2 samples (one high, one low).

## Configuration
- Macro: `SIGNAL_MEASURE_AVG_EN`.
- **Defined:**
  - Four consecutive periods are summed in a CNT_W+2-bit accumulator; `period` = sum>>2.
  - `meas_valid` pulses on every 4th publish only.
  - `amp_*` come from the 4th window.
  - A timeout or reset clears the accumulator and the 4-count.
- **Undefined:** each period is published directly.

## Structure
- Shared package `signal_measure_pkg`:
  - state enum (SEEK, ARM, RUN_HI, RUN_LO)
  - default DATA_W/CNT_W/HYST/MID_INIT constants
- One natural sub-module, `minmax_track`, holds running min/max with a restart input.
- The FSM, counter, mid register and averaging stay in the top level.

## Test plan
- Square wave 0/3825, 50 high + 50 low, `in_valid`=1 every cycle → from the second rising crossing onward: `period`=100, `amp_max`=3825, `amp_min`=0, `amp_pp`=3825, one `meas_valid` per 100 cycles, `mid`→1912.
- Same wave with `in_valid` asserted every other cycle, each sample held for 2 cycles → `period`=100 (accepted samples only), pulse every 200 cycles.
- Constant 2000 → no pulse; `no_signal`=1 after 65535 accepted samples; `mid` returns to 2048.
- Square 0/255, period 64 → first window times out, `mid`=127, then `period`=64, `amp_pp`=255, `no_signal` clears on the first publish.
- `rst` asserted for 1 cycle during RUN_LO → all outputs 0 next cycle. The first crossing after reset gives no pulse; the second gives a correct period.
- With `SIGNAL_MEASURE_AVG_EN`, periods 100, 102, 98, 100 → a single `meas_valid` with `period`=100.
